palette_lut: RTL and testbench
==============================

# palette_lut

Programmable, pipelined 256-entry-class palette lookup that turns a stream of colour indices into RGB triples for the display path. On reset, or on request, it fills its RAM with the default palette (6×6×6 web-safe cube, R/G/B/grey ramps, black) through an internal init sequencer. A host write port then overrides entries at runtime. Pixel traffic uses valid/ready on both sides, delivers one pixel per cycle, and has a fixed 2-cycle latency.

## Interface
Parameters:
- INDEX_W, 8, index width; must be ≥ 8; depth = 2^INDEX_W
- CHAN_W, 8, bits per colour channel; must be ≥ 1

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low
- init_req  in  1  one-cycle pulse: reload the default palette
- busy  out  1  init sequencer running
- wr_en  in  1  host write strobe
- wr_ready  out  1  equals ~busy; a write is accepted only when wr_en & wr_ready
- wr_addr  in  INDEX_W  host write address
- wr_data  in  3*CHAN_W  {R,G,B}
- pix_valid  in  1  input index valid
- pix_ready  out  1  input accepted when pix_valid & pix_ready
- pix_index  in  INDEX_W  colour index
- out_valid  out  1  RGB valid
- out_ready  in  1  downstream accept
- r_value / g_value / b_value  out  CHAN_W each  looked-up colour

## Operation
- **Default palette**, indices 0..214: cube. The index decomposes as r_d*36 + g_d*6 + b_d, with each digit in 0..5. Channel value = (5−d)*0x33. So index 0 = ffffff and index 214 = 000033.
- **Ramps.** Ramp order is ee,dd,bb,aa,88,77,55,44,22,11.
  - 215..224: red ramp, G=B=0.
  - 225..234: green ramp.
  - 235..244: blue ramp.
  - 245..254: grey ramp (all three channels equal).
- **Fixed entries.** Index 255 = 000000. Indices ≥ 256 = 0.
- **Channel width.** Default values are 8-bit.
  - CHAN_W < 8: keep the top CHAN_W bits.
  - CHAN_W > 8: replicate the 8-bit pattern MSB-first, then truncate.
  - Host-written data is stored verbatim.
- **Init FSM**, states IDLE and FILL.
  - Reset leaves the FSM in FILL with address 0.
  - FILL writes one entry per cycle, address 0..2^INDEX_W−1. It is generated by b/g/r digit counters plus a ramp counter, with no divider.
  - After the last address the FSM moves to IDLE.
  - init_req while IDLE moves to FILL at address 0. init_req while in FILL restarts at address 0.
  - busy = (state == FILL).
- **Host writes** are ignored while busy (wr_ready = 0). The write takes effect for reads issued on the following cycle or later.
- **RAM.** Simple dual-port, 1 write / 1 read, read-first. A read and a write to the same address in the same cycle returns the old data.
- **Pipeline.**
  - S1 is the registered RAM read, S2 the output register. Both stages carry a valid bit.
  - advance = ~out_valid | out_ready. Both stages shift only on advance.
  - pix_ready = advance & ~busy.
- **In-flight pixels** when init starts complete normally with their already-read data. New indices are blocked until busy drops.

## Timing
- **Reset values:** busy=1, wr_ready=0, pix_ready=0, out_valid=0, r/g/b=0. All pipeline valid bits and the FSM address are cleared asynchronously.
- **Init duration:** 2^INDEX_W cycles. busy deasserts on the cycle after the last entry is written, which is 256 cycles after rst_n release for INDEX_W=8. The first lookup can be accepted that cycle.
- **init_req timing:** busy rises the cycle after init_req.
- **Latency:** index accepted at cycle N → out_valid with its colour at N+2, provided no stall.
- **Throughput:** 1 pixel/cycle while out_ready stays high.
- **Stall:** with out_ready=0 and out_valid=1, r/g/b and out_valid hold stable and pix_ready=0. No data is lost or duplicated. out_valid never drops without a handshake.
- **Reset mid-operation:** in-flight pixels are discarded, and init restarts from address 0.

## Structure
- **Package palette_pkg:** the cube step constant 8'h33, the cube digit max 5, the 10-entry ramp constant array, segment boundary indices (215, 225, 235, 245, 255), an rgb struct typedef, and a scale8 function for CHAN_W conversion.
- **Sub-module palette_ram:** parametrised depth/width, 1W1R, read-first, registered read output with a read enable. Only the wrapper holds the init FSM and handshake logic.

## Test plan
- Release reset, wait for busy=0 (256 cycles), read all 256 indices back-to-back → every output matches the default palette. Spot checks: 0→ffffff, 43→cccccc, 214→000033, 215→ee0000, 250→777777, 255→000000.
- Write idx 5 = 123456 while not busy, read 5 on the next cycle → 123456. Write and read idx 5 in the same cycle → old value ffff00.
- Stream 8 indices while out_ready toggles 1,0,0,1,… → the outputs arrive in order with none lost or duplicated, r/g/b stay stable while stalled, and the latency is 2 cycles when unstalled.
- Overwrite idx 0 = 000000, pulse init_req → busy=1 for 256 cycles and wr_ready=0, with writes during that window ignored. Afterwards idx 0 reads ffffff.
- Pulse init_req at fill address 100 → the fill restarts at 0 and busy lasts 256 cycles from the second pulse.
- Assert rst_n low mid-stream with 2 pixels in flight → out_valid=0 immediately, and no stale pixel appears after release.

Source files
------------

// File: rtl/palette_pkg.sv
// rtl/palette_pkg.sv - shared constants, types and helpers for the palette lookup
package palette_pkg;

    localparam logic [7:0] CUBE_STEP = 8'h33;
    localparam logic [2:0] CUBE_MAX  = 3'd5;
    localparam logic [3:0] RAMP_LAST = 4'd9;

    localparam logic [0:9][7:0] RAMP = {
        8'hee, 8'hdd, 8'hbb, 8'haa, 8'h88, 8'h77, 8'h55, 8'h44, 8'h22, 8'h11
    };

    localparam logic [7:0] SEG_RED   = 8'd215;
    localparam logic [7:0] SEG_GREEN = 8'd225;
    localparam logic [7:0] SEG_BLUE  = 8'd235;
    localparam logic [7:0] SEG_GREY  = 8'd245;
    localparam logic [7:0] SEG_BLACK = 8'd255;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    typedef enum logic {ST_IDLE, ST_FILL} init_state_e;

    function automatic logic [7:0] cube_val(input logic [2:0] d);
        logic [7:0] k;
        k = {5'd0, CUBE_MAX - d};
        return k * CUBE_STEP;
    endfunction

    // Top chan_w bits of the byte repeated MSB-first; covers both narrowing and widening.
    function automatic logic [63:0] scale8(input logic [7:0] v, input int chan_w);
        logic [63:0] rep;
        rep = {8{v}};
        return rep >> (64 - chan_w);
    endfunction

endpackage

// File: rtl/palette_ram.sv
// rtl/palette_ram.sv - 1W1R read-first RAM with registered, enabled read port
module palette_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [1<<ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Both assignments are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/palette_lut.sv
// rtl/palette_lut.sv - palette lookup: init sequencer, host write port, 2-stage pixel pipe
module palette_lut
    import palette_pkg::*;
#(
    parameter int INDEX_W = 8,
    parameter int CHAN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    output logic                  busy,
    input  logic                  wr_en,
    output logic                  wr_ready,
    input  logic [INDEX_W-1:0]    wr_addr,
    input  logic [3*CHAN_W-1:0]   wr_data,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [INDEX_W-1:0]    pix_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHAN_W-1:0]     r_value,
    output logic [CHAN_W-1:0]     g_value,
    output logic [CHAN_W-1:0]     b_value
);

    localparam int DATA_W = 3 * CHAN_W;
    localparam logic [INDEX_W-1:0] LAST_ADDR = '1;

    init_state_e        state_q, state_d;
    logic [INDEX_W-1:0] addr_q, addr_d;
    logic [2:0]         bd_q, bd_d, gd_q, gd_d, rd_q, rd_d;
    logic [3:0]         ramp_q, ramp_d;
    logic               s1_valid_q, s1_valid_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  rgb_q, rgb_d;

    logic               in_low, restart, advance;
    logic [7:0]         lo;
    rgb8_t              def8;
    logic [DATA_W-1:0]  def_rgb, ram_rdata;

    assign lo     = addr_q[7:0];
    assign in_low = (addr_q >> 8) == '0;

    always_comb begin
        def8 = '0;
        if (in_low) begin
            if (lo < SEG_RED)        def8 = '{cube_val(rd_q), cube_val(gd_q), cube_val(bd_q)};
            else if (lo < SEG_GREEN) def8.r = RAMP[ramp_q];
            else if (lo < SEG_BLUE)  def8.g = RAMP[ramp_q];
            else if (lo < SEG_GREY)  def8.b = RAMP[ramp_q];
            else if (lo < SEG_BLACK) def8 = '{RAMP[ramp_q], RAMP[ramp_q], RAMP[ramp_q]};
        end
    end

    assign def_rgb = {CHAN_W'(scale8(def8.r, CHAN_W)),
                      CHAN_W'(scale8(def8.g, CHAN_W)),
                      CHAN_W'(scale8(def8.b, CHAN_W))};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bd_d    = bd_q;
        gd_d    = gd_q;
        rd_d    = rd_q;
        ramp_d  = ramp_q;
        restart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_FILL;
                    restart = 1'b1;
                end
            end
            ST_FILL: begin
                if (init_req) begin
                    restart = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    restart = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                    // Digit counters walk the cube in index order; the ramp counter cycles per segment.
                    if (in_low && lo < SEG_RED) begin
                        if (bd_q == CUBE_MAX) begin
                            bd_d = 3'd0;
                            if (gd_q == CUBE_MAX) begin
                                gd_d = 3'd0;
                                rd_d = rd_q + 3'd1;
                            end else begin
                                gd_d = gd_q + 3'd1;
                            end
                        end else begin
                            bd_d = bd_q + 3'd1;
                        end
                    end else if (in_low && lo < SEG_BLACK) begin
                        ramp_d = (ramp_q == RAMP_LAST) ? 4'd0 : ramp_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
        if (restart) begin
            addr_d = '0;
            bd_d   = 3'd0;
            gd_d   = 3'd0;
            rd_d   = 3'd0;
            ramp_d = 4'd0;
        end
    end

    assign busy      = (state_q == ST_FILL);
    assign wr_ready  = ~busy;
    assign advance   = ~out_valid_q | out_ready;
    assign pix_ready = advance & ~busy;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        rgb_d       = rgb_q;
        if (advance) begin
            s1_valid_d  = pix_valid & pix_ready;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) rgb_d = ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            addr_q      <= '0;
            bd_q        <= 3'd0;
            gd_q        <= 3'd0;
            rd_q        <= 3'd0;
            ramp_q      <= 4'd0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bd_q        <= bd_d;
            gd_q        <= gd_d;
            rd_q        <= rd_d;
            ramp_q      <= ramp_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
        end
    end

    palette_ram #(
        .ADDR_W (INDEX_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (busy | wr_en),
        .waddr (busy ? addr_q : wr_addr),
        .wdata (busy ? def_rgb : wr_data),
        .re    (advance),
        .raddr (pix_index),
        .rdata (ram_rdata)
    );

    assign out_valid = out_valid_q;
    assign r_value   = rgb_q[DATA_W-1 -: CHAN_W];
    assign g_value   = rgb_q[2*CHAN_W-1 -: CHAN_W];
    assign b_value   = rgb_q[CHAN_W-1:0];

endmodule

// File: tb/tb_palette_lut.sv
// tb/tb_palette_lut.sv - scoreboard bench for palette_lut against a reference palette model
module tb_palette_lut;

    logic        clk = 1'b0;
    logic        rst_n, init_req, busy, wr_en, wr_ready;
    logic [7:0]  wr_addr, pix_index;
    logic [23:0] wr_data;
    logic        pix_valid, pix_ready, out_valid, out_ready;
    logic [7:0]  r_value, g_value, b_value;

    always #5 clk = ~clk;

    palette_lut #(.INDEX_W(8), .CHAN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_index(pix_index),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_value(r_value), .g_value(g_value), .b_value(b_value)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] model [256];
    logic [23:0] exp_q [$];
    logic [7:0]  ramp_tab [10] = '{8'hee, 8'hdd, 8'hbb, 8'haa, 8'h88, 8'h77, 8'h55, 8'h44, 8'h22, 8'h11};
    logic        spot_en = 1'b0;
    logic [23:0] spot_val = '0;
    logic        last_acc;

    function automatic logic [23:0] default_rgb(input int i);
        int r, g, b;
        if (i <= 214) begin
            r = i / 36;
            g = (i / 6) % 6;
            b = i % 6;
            return {8'((5 - r) * 51), 8'((5 - g) * 51), 8'((5 - b) * 51)};
        end
        if (i <= 224) return {ramp_tab[i-215], 16'h0};
        if (i <= 234) return {8'h0, ramp_tab[i-225], 8'h0};
        if (i <= 244) return {16'h0, ramp_tab[i-235]};
        if (i <= 254) return {3{ramp_tab[i-245]}};
        return 24'h0;
    endfunction

    task automatic reload_model();
        for (int i = 0; i < 256; i++) model[i] = default_rgb(i);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic pv, input logic [7:0] idx, input logic ordy,
                        input logic we, input logic [7:0] wa, input logic [23:0] wd,
                        input logic ireq);
        @(negedge clk);
        pix_valid = pv; pix_index = idx; out_ready = ordy;
        wr_en = we; wr_addr = wa; wr_data = wd; init_req = ireq;
        #1;
        check("wr_ready_rule", {31'd0, wr_ready}, {31'd0, ~busy});
        check("pix_ready_rule", {31'd0, pix_ready}, {31'd0, (~out_valid | ordy) & ~busy});
        last_acc = pv & pix_ready;
        if (last_acc) exp_q.push_back(spot_en ? spot_val : model[idx]);
        if (we && wr_ready) model[wa] = wd;
        if (ireq) reload_model();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 8'h0, ordy, 1'b0, 8'h0, 24'h0, 1'b0);
    endtask

    task automatic spot(input logic [7:0] idx, input logic [23:0] val);
        spot_en = 1'b1; spot_val = val;
        step(1'b1, idx, 1'b1, 1'b0, 8'h0, 24'h0, 1'b0);
        spot_en = 1'b0;
    endtask

    task automatic count_busy(input logic do_writes, output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            step(1'b0, 8'h0, 1'b1, do_writes, 8'($urandom_range(0, 255)), 24'h0, 1'b0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    logic        stall_prev = 1'b0;
    logic [23:0] stall_data;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
                    check("stall_data_hold", {r_value, g_value, b_value}, stall_data);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_pixel: got %h expected none", {r_value, g_value, b_value});
                    end else begin
                        check("pixel", {r_value, g_value, b_value}, exp_q.pop_front());
                    end
                end
                stall_prev = out_valid & ~out_ready;
                stall_data = {r_value, g_value, b_value};
            end
        end
    end

    initial begin
        int n, sent, cyc;
        logic [7:0] idxs [8];
        logic [3:0] pat;

        rst_n = 1'b0; init_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pix_valid = 1'b0; pix_index = '0; out_ready = 1'b1;
        reload_model();
        @(negedge clk); #1;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_rgb", {r_value, g_value, b_value}, 24'h0);

        @(negedge clk); rst_n = 1'b1; #1;
        count_busy(1'b0, n);
        check("init_cycles_reset", n, 256);

        for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 8'h0, 24'h0, 1'b0);
        drain();

        spot(8'd0, 24'hffffff);   spot(8'd43, 24'hcccccc);  spot(8'd214, 24'h000033);
        spot(8'd215, 24'hee0000); spot(8'd250, 24'h777777); spot(8'd255, 24'h000000);
        spot(8'd230, 24'h007700); spot(8'd244, 24'h000011);
        drain();

        spot_en = 1'b1; spot_val = 24'hffff00;
        step(1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 24'h123456, 1'b0);
        spot_en = 1'b0;
        spot(8'd5, 24'h123456);
        drain();

        step(1'b1, 8'd7, 1'b1, 1'b0, 8'h0, 24'h0, 1'b0);
        idle(1'b1);
        check("latency_n1", {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        check("latency_n2", {31'd0, out_valid}, 32'd1);
        drain();

        pat = 4'b1001;
        for (int k = 0; k < 8; k++) idxs[k] = 8'($urandom_range(0, 255));
        sent = 0; cyc = 0;
        while (sent < 8 && cyc < 200) begin
            step(1'b1, idxs[sent], pat[3 - (cyc % 4)], 1'b0, 8'h0, 24'h0, 1'b0);
            if (last_acc) sent++;
            cyc++;
        end
        check("stall_stream_sent", sent, 8);
        for (int k = 0; k < 12; k++) idle(pat[3 - (k % 4)]);
        drain();

        step(1'b0, 8'h0, 1'b1, 1'b1, 8'd0, 24'h000000, 1'b0);
        spot(8'd0, 24'h000000);
        drain();
        step(1'b0, 8'h0, 1'b1, 1'b0, 8'h0, 24'h0, 1'b1);
        check("busy_low_at_req", {31'd0, busy}, 32'd0);
        idle(1'b1);
        count_busy(1'b1, n);
        check("init_cycles_req", n, 256);
        spot(8'd0, 24'hffffff);
        drain();

        step(1'b0, 8'h0, 1'b1, 1'b0, 8'h0, 24'h0, 1'b1);
        idle(1'b1);
        for (int k = 0; k < 100; k++) idle(1'b1);
        step(1'b0, 8'h0, 1'b1, 1'b0, 8'h0, 24'h0, 1'b1);
        idle(1'b1);
        count_busy(1'b0, n);
        check("init_cycles_restart", n, 256);

        step(1'b1, 8'd43, 1'b1, 1'b0, 8'h0, 24'h0, 1'b0);
        step(1'b1, 8'd215, 1'b1, 1'b0, 8'h0, 24'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        reload_model();
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        count_busy(1'b0, n);
        check("init_cycles_midreset", n, 256);
        drain();

        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, 8'($urandom), 24'($urandom),
                 $urandom_range(0, 399) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
